// File: rtl/cpu_types_pkg.sv
// Shared CPU types: address/frame layouts and FSM states for the instruction cache.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int ICACHE_SETS  = 16;
    localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAG_W = 32 - ICACHE_IDX_W - 2;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icache_addr_t;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        word_t                   data;
    } icache_frame_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

    function automatic word_t sat_inc(input word_t v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-controller-side signals of one instruction cache.
interface icache_if;
    import cpu_types_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  flush;
    logic  ihit;
    word_t imemload;
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;

    // slave is the cache itself; master is the core plus memory controller around it
    modport slave (
        input  imemREN, imemaddr, flush, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, flush, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );

endinterface

// File: rtl/icache_frames.sv
// Direct-mapped frame store: async-reset valid bits, one fill port, global clear, combinational read.
module icache_frames
    import cpu_types_pkg::*;
#(
    parameter  int SETS  = ICACHE_SETS,
    localparam int IDX_W = $clog2(SETS),
    localparam int TAG_W = 32 - IDX_W - 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  word_t            wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output word_t            rd_data
);

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tags [SETS];
    word_t            data [SETS];

    // Flush wins over a same-cycle fill so the filled frame stays invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx] <= wr_tag;
            data[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = data[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: same-cycle hits, single-word refill on a miss.
// The refill cannot be cancelled; a redirect during FETCH is looked up once the fill completes.
module icache
    import cpu_types_pkg::*;
#(
    parameter int SETS = ICACHE_SETS
) (
    input  logic    CLK,
    input  logic    RST,
    icache_if.slave bus,
    output word_t   hit_count,
    output word_t   miss_count
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - IDX_W - 2;

    icache_state_t    state;
    word_t            miss_addr;
    logic             ren;
    word_t            hit_cnt;
    word_t            miss_cnt;

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    word_t            rd_data;
    logic             hit;
    logic             miss;
    logic             fill;
    logic             unused_offset;

    assign req_idx       = bus.imemaddr[IDX_W+1:2];
    assign req_tag       = bus.imemaddr[31:IDX_W+2];
    assign unused_offset = ^bus.imemaddr[1:0];

    assign hit  = (state == IDLE) && bus.imemREN && rd_valid && (rd_tag == req_tag);
    assign miss = (state == IDLE) && bus.imemREN && !hit;
    assign fill = (state == FETCH) && !bus.iwait;

    icache_frames #(
        .SETS(SETS)
    ) frames (
        .clk     (CLK),
        .rst     (RST),
        .flush   (bus.flush),
        .wr_en   (fill),
        .wr_idx  (miss_addr[IDX_W+1:2]),
        .wr_tag  (miss_addr[31:IDX_W+2]),
        .wr_data (bus.iload),
        .rd_idx  (req_idx),
        .rd_valid(rd_valid),
        .rd_tag  (rd_tag),
        .rd_data (rd_data)
    );

    // iREN is a flop so the controller never sees a combinational path from imemREN.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            miss_addr <= '0;
            ren       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        miss_addr <= {bus.imemaddr[31:2], 2'b00};
                        ren       <= 1'b1;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (!bus.iwait) begin
                        ren   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    ren   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit) begin
                hit_cnt <= sat_inc(hit_cnt);
            end
            if (miss) begin
                miss_cnt <= sat_inc(miss_cnt);
            end
        end
    end

    assign bus.ihit     = hit;
    assign bus.imemload = hit ? rd_data : '0;
    assign bus.iREN     = ren;
    assign bus.iaddr    = miss_addr;
    assign hit_count    = hit_cnt;
    assign miss_count   = miss_cnt;

endmodule
